srm_spike_fire: RTL and testbench

//  Output stage of the SRM0 neuron: takes the summed membrane voltage from the

---
 rtl/srm_spike_fire.sv | 103 ++++++++++
 tb/tb_srm_spike_fire.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/srm_spike_fire.sv
// SRM0 neuron output stage: thresholds the summed membrane voltage, emits a spike,
// enforces a refractory period and feeds the decayed voltage back to summation.
module srm_spike_fire #(
    parameter int unsigned WIDTH          = 14,
    parameter int unsigned THRESHOLD      = 1000,
    parameter int unsigned REFRACT_CYCLES = 4,
    parameter int unsigned DECAY_SHIFT    = 3,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic [WIDTH-1:0]     i_sum_voltage,
    output logic [WIDTH-1:0]     o_cond_decay,
    output logic                 o_spike,
    output logic                 o_refractory,
    output logic [CNT_WIDTH-1:0] o_spike_count
);

    // rcnt only ever holds REFRACT_CYCLES-1 down to 0
    localparam int unsigned RCNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_INIT =
        (REFRACT_CYCLES > 0) ? RCNT_W'(REFRACT_CYCLES - 1) : '0;
    localparam logic [WIDTH-1:0] THRESH = WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {
        StIntegrate,
        StFire,
        StRefract
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WIDTH-1:0]      r_v;
    logic [WIDTH-1:0]      w_v_next;
    logic [RCNT_W-1:0]     r_rcnt;
    logic [RCNT_W-1:0]     w_rcnt_next;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_count_next;

    always_comb begin
        w_state_next = r_state;
        w_v_next     = r_v;
        w_rcnt_next  = r_rcnt;
        w_count_next = r_count;
        unique case (r_state)
            StIntegrate: begin
                if (i_valid) begin
                    if (i_sum_voltage >= THRESH) begin
                        w_v_next     = '0;
                        w_count_next = (r_count == '1) ? r_count : r_count + 1'b1;
                        w_state_next = StFire;
                    end else begin
                        w_v_next = i_sum_voltage;
                    end
                end
            end
            StFire: begin
                w_v_next = '0;
                if (REFRACT_CYCLES == 0) begin
                    w_state_next = StIntegrate;
                end else begin
                    w_rcnt_next  = RCNT_INIT;
                    w_state_next = StRefract;
                end
            end
            StRefract: begin
                w_v_next = '0;
                if (r_rcnt == '0) begin
                    w_state_next = StIntegrate;
                end else begin
                    w_rcnt_next = r_rcnt - 1'b1;
                end
            end
            default: begin
                w_v_next     = '0;
                w_state_next = StIntegrate;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIntegrate;
            r_v     <= '0;
            r_rcnt  <= '0;
            r_count <= '0;
        end else if (i_enable) begin
            r_state <= w_state_next;
            r_v     <= w_v_next;
            r_rcnt  <= w_rcnt_next;
            r_count <= w_count_next;
        end
    end

    // Spike is gated by enable so a frozen neuron never emits a pulse
    assign o_spike       = i_enable && (r_state == StFire);
    assign o_refractory  = (r_state != StIntegrate);
    assign o_cond_decay  = r_v - (r_v >> DECAY_SHIFT);
    assign o_spike_count = r_count;

endmodule

// File: tb/tb_srm_spike_fire.sv
// Bench for srm_spike_fire: default instance plus a CNT_WIDTH=3 / REFRACT_CYCLES=0 instance,
// both driven identically and checked against a cycle model through a scoreboard queue.
module tb_srm_spike_fire;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        valid;
    logic [13:0] sum;

    logic [13:0] d1_decay;
    logic        d1_spike;
    logic        d1_refr;
    logic [15:0] d1_count;
    logic [13:0] d2_decay;
    logic        d2_spike;
    logic        d2_refr;
    logic [2:0]  d2_count;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [13:0] decay;
        logic        spike;
        logic        refr;
        logic [15:0] count;
    } exp_t;

    typedef struct {
        int ph;    // 0 integrate, 1 fire, 2 refractory
        int v;
        int left;
        int cnt;
    } mdl_t;

    exp_t q1[$];
    exp_t q2[$];
    mdl_t m1 = '{0, 0, 0, 0};
    mdl_t m2 = '{0, 0, 0, 0};

    srm_spike_fire u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (enable),
        .i_valid       (valid),
        .i_sum_voltage (sum),
        .o_cond_decay  (d1_decay),
        .o_spike       (d1_spike),
        .o_refractory  (d1_refr),
        .o_spike_count (d1_count)
    );

    srm_spike_fire #(
        .REFRACT_CYCLES (0),
        .CNT_WIDTH      (3)
    ) u_dut2 (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (enable),
        .i_valid       (valid),
        .i_sum_voltage (sum),
        .o_cond_decay  (d2_decay),
        .o_spike       (d2_spike),
        .o_refractory  (d2_refr),
        .o_spike_count (d2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mstep(mdl_t s, logic rst_n, logic en, logic vld, int sv,
                                   int refr, int cmax);
        mdl_t n = s;
        if (!rst_n) begin
            n = '{0, 0, 0, 0};
        end else if (en) begin
            case (s.ph)
                0: begin
                    if (vld) begin
                        if (sv >= 1000) begin
                            n.v  = 0;
                            n.ph = 1;
                            if (s.cnt < cmax) n.cnt = s.cnt + 1;
                        end else begin
                            n.v = sv;
                        end
                    end
                end
                1: begin
                    if (refr == 0) n.ph = 0;
                    else begin
                        n.ph   = 2;
                        n.left = refr;
                    end
                end
                default: begin
                    n.left = s.left - 1;
                    if (n.left == 0) n.ph = 0;
                end
            endcase
        end
        return n;
    endfunction

    function automatic exp_t mout(mdl_t s, logic en);
        exp_t e;
        e.decay = 14'(s.v - s.v / 8);
        e.spike = (s.ph == 1) && en;
        e.refr  = (s.ph != 0);
        e.count = 16'(s.cnt);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, queue model expectations, sample after the edge and compare
    task automatic cyc(input logic rst_n, input logic en, input logic vld, input int sv);
        exp_t e;
        reset  = rst_n;
        enable = en;
        valid  = vld;
        sum    = 14'(sv);
        m1 = mstep(m1, rst_n, en, vld, sv, 4, 65535);
        m2 = mstep(m2, rst_n, en, vld, sv, 0, 7);
        q1.push_back(mout(m1, en));
        q2.push_back(mout(m2, en));
        @(posedge clk);
        #1;
        e = q1.pop_front();
        chk("d1.decay", 32'(d1_decay), 32'(e.decay));
        chk("d1.spike", 32'(d1_spike), 32'(e.spike));
        chk("d1.refr",  32'(d1_refr),  32'(e.refr));
        chk("d1.count", 32'(d1_count), 32'(e.count));
        e = q2.pop_front();
        chk("d2.decay", 32'(d2_decay), 32'(e.decay));
        chk("d2.spike", 32'(d2_spike), 32'(e.spike));
        chk("d2.refr",  32'(d2_refr),  32'(e.refr));
        chk("d2.count", 32'(d2_count), 32'(e.count));
    endtask

    initial begin
        int refr_n;
        int spk;

        reset  = 1'b0;
        enable = 1'b1;
        valid  = 1'b0;
        sum    = '0;
        @(negedge clk);

        cyc(1'b0, 1'b1, 1'b0, 0);
        chk("rst.spike", 32'(d1_spike), 0);
        chk("rst.refr",  32'(d1_refr),  0);
        chk("rst.decay", 32'(d1_decay), 0);
        chk("rst.count", 32'(d1_count), 0);

        // Sub-threshold integrate
        cyc(1'b1, 1'b1, 1'b1, 500);
        chk("t1.decay", 32'(d1_decay), 438);
        chk("t1.spike", 32'(d1_spike), 0);

        // Equality fires; refractory spans 5 cycles; input during it is dropped
        cyc(1'b1, 1'b1, 1'b1, 1000);
        chk("t2.spike", 32'(d1_spike), 1);
        chk("t2.count", 32'(d1_count), 1);
        refr_n = int'(d1_refr);
        spk    = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 2000);
            refr_n += int'(d1_refr);
            spk    += int'(d1_spike);
        end
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("t2.refr_end",   32'(d1_refr), 0);
        chk("t2.refr_len",   32'(refr_n), 5);
        chk("t2.no_respike", 32'(spk), 0);
        chk("t2.count_hold", 32'(d1_count), 1);

        // Held supra-threshold input: one spike per 6 cycles
        spk = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1200);
            spk += int'(d1_spike);
        end
        chk("t3.spikes", 32'(spk), 5);
        chk("t3.count",  32'(d1_count), 6);

        // Reset in the second refractory cycle
        cyc(1'b1, 1'b1, 1'b1, 1000);
        cyc(1'b1, 1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("t4.in_refr", 32'(d1_refr), 1);
        cyc(1'b0, 1'b1, 1'b1, 1000);
        chk("t4.spike", 32'(d1_spike), 0);
        chk("t4.refr",  32'(d1_refr),  0);
        chk("t4.decay", 32'(d1_decay), 0);
        chk("t4.count", 32'(d1_count), 0);
        cyc(1'b1, 1'b1, 1'b1, 1000);
        chk("t4.refire", 32'(d1_spike), 1);
        chk("t4.count1", 32'(d1_count), 1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 0);

        // One below threshold does not fire
        cyc(1'b1, 1'b1, 1'b1, 999);
        chk("thr.spike", 32'(d1_spike), 0);
        chk("thr.decay", 32'(d1_decay), 875);

        // Enable freeze
        cyc(1'b1, 1'b1, 1'b1, 700);
        chk("t5.decay", 32'(d1_decay), 613);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1500);
            chk("t5.frozen_spike", 32'(d1_spike), 0);
            chk("t5.frozen_decay", 32'(d1_decay), 613);
        end
        cyc(1'b1, 1'b1, 1'b1, 1500);
        chk("t5.spike", 32'(d1_spike), 1);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("t5.gated_spike", 32'(d1_spike), 0);
        chk("t5.gated_refr",  32'(d1_refr),  1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 0);

        // Saturating 3-bit counter with zero refractory
        cyc(1'b0, 1'b1, 1'b0, 0);
        spk = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1200);
            spk += int'(d2_spike);
        end
        chk("t6.spikes", 32'(spk), 8);
        chk("t6.count",  32'(d2_count), 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
